// File: rtl/picoblaze_io_bridge.sv
// I/O bridge for kcpsm6: output holding registers, registered input mux,
// maskable edge-triggered interrupt controller and key-code pulse decoder.
module picoblaze_io_bridge #(
  parameter int              DW            = 8,
  parameter int              N_OUT         = 4,
  parameter int              N_IN          = 4,
  parameter int              N_IRQ         = 4,
  parameter logic [7:0]      OUT_BASE      = 8'h01,
  parameter logic [7:0]      IN_BASE       = 8'h20,
  parameter logic [7:0]      IRQ_STAT_PORT = 8'h30,
  parameter logic [7:0]      IRQ_MASK_PORT = 8'h31,
  parameter int              KEY_CH        = 0,
  parameter logic [DW-1:0]   KEY_INC       = 8'h1d,
  parameter logic [DW-1:0]   KEY_DEC       = 8'h1b
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic [DW-1:0]        out_port,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  output logic [DW-1:0]        cpu_in_port,
  input  logic [N_IN*DW-1:0]   ext_in,
  output logic [N_OUT*DW-1:0]  out_regs,
  output logic [N_OUT-1:0]     out_valid,
  input  logic [N_IRQ-1:0]     irq_src,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  output logic [N_IRQ-1:0]     irq_pending,
  output logic                 inc_pulse,
  output logic                 dec_pulse
);

  logic [N_OUT-1:0] wr_hit;
  logic             key_hit;
  logic             stat_wr;
  logic             mask_wr;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             in_service;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] irq_clr;
  logic [N_IRQ-1:0] pending_nxt;
  logic [N_IRQ-1:0] mask_nxt;
  logic             in_service_nxt;
  logic             interrupt_nxt;
  logic [DW-1:0]    rd_data;
  logic             unused_inputs;

  // Reads have no side effects, so the read qualifier is deliberately ignored.
  assign unused_inputs = read_strobe;
  assign irq_pending   = pending;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_OUT; i++)
      wr_hit[i] = write_strobe && (port_id == OUT_BASE + 8'(i));
  end

  assign key_hit = write_strobe && (port_id == OUT_BASE + 8'(KEY_CH));
  assign stat_wr = write_strobe && (port_id == IRQ_STAT_PORT);
  assign mask_wr = write_strobe && (port_id == IRQ_MASK_PORT);

  // Next-state interrupt values; interrupt is registered from these so that an
  // ack or an ISR clear takes effect on the very next cycle. A new edge beats a clear.
  always_comb begin
    irq_edge       = irq_src & ~irq_prev;
    irq_clr        = stat_wr ? out_port[N_IRQ-1:0] : '0;
    pending_nxt    = (pending & ~irq_clr) | irq_edge;
    mask_nxt       = mask_wr ? out_port[N_IRQ-1:0] : mask;
    in_service_nxt = in_service;
    if (stat_wr)
      in_service_nxt = 1'b0;
    else if (interrupt_ack)
      in_service_nxt = 1'b1;
    interrupt_nxt  = (|(pending_nxt & mask_nxt)) && !in_service_nxt;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_IN; i++)
      if (port_id == IN_BASE + 8'(i))
        rd_data = ext_in[i*DW +: DW];
    if (port_id == IRQ_STAT_PORT)
      rd_data = DW'(pending);
    if (port_id == IRQ_MASK_PORT)
      rd_data = DW'(mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_regs    <= '0;
      out_valid   <= '0;
      cpu_in_port <= '0;
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (wr_hit[i])
          out_regs[i*DW +: DW] <= out_port;
      out_valid   <= wr_hit;
      cpu_in_port <= rd_data;
      inc_pulse   <= key_hit && (out_port == KEY_INC);
      dec_pulse   <= key_hit && (out_port == KEY_DEC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev   <= '0;
      pending    <= '0;
      mask       <= '0;
      in_service <= 1'b0;
      interrupt  <= 1'b0;
    end else begin
      irq_prev   <= irq_src;
      pending    <= pending_nxt;
      mask       <= mask_nxt;
      in_service <= in_service_nxt;
      interrupt  <= interrupt_nxt;
    end
  end

endmodule
